// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main control FSM.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_IMM_EXEC = 4'd9,
        S_IMM_WB   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12,
        S_ILLEGAL  = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [1:0] ALUOP_FUNCT = 2'b00;
    localparam logic [1:0] ALUOP_ADD   = 2'b01;
    localparam logic [1:0] ALUOP_SUB   = 2'b10;
    localparam logic [1:0] ALUOP_AND   = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic       SRCA_PC  = 1'b0;
    localparam logic       SRCA_REG = 1'b1;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational control-word decode: (state, latched opcode, zero) -> datapath controls.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic [5:0] op_i,
    input  logic       zero_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o        = '0;
        // The ALU-control decoder only sees 00 while an R-type is executing.
        ctrl_o.alu_op = ALUOP_ADD;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_src    = PCSRC_ALU;
                ctrl_o.alu_src_a = SRCA_PC;
                ctrl_o.alu_src_b = SRCB_FOUR;
            end
            S_DECODE: begin
                ctrl_o.alu_src_a = SRCA_PC;
                ctrl_o.alu_src_b = SRCB_IMM_SH;
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = SRCA_REG;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REGDST_RT;
                ctrl_o.mem_to_reg = M2R_MDR;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.i_or_d     = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_R_EXEC: begin
                ctrl_o.alu_src_a = SRCA_REG;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REGDST_RD;
                ctrl_o.mem_to_reg = M2R_ALUOUT;
                ctrl_o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a  = SRCA_REG;
                ctrl_o.alu_src_b  = SRCB_B;
                ctrl_o.alu_op     = ALUOP_SUB;
                ctrl_o.pc_src     = PCSRC_ALUOUT;
                ctrl_o.pc_write   = zero_i ^ (op_i == OP_BNE);
                ctrl_o.instr_done = 1'b1;
            end
            S_IMM_EXEC: begin
                ctrl_o.alu_src_a = SRCA_REG;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = (op_i == OP_ANDI) ? ALUOP_AND : ALUOP_ADD;
            end
            S_IMM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REGDST_RT;
                ctrl_o.mem_to_reg = M2R_ALUOUT;
                ctrl_o.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_src     = PCSRC_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
            S_JAL: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_src     = PCSRC_JUMP;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REGDST_RA;
                ctrl_o.mem_to_reg = M2R_PC;
                ctrl_o.instr_done = 1'b1;
            end
            S_ILLEGAL: begin
                ctrl_o.illegal_op = 1'b1;
            end
            default: begin
                ctrl_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS main control: state register, latched opcode and next-state dispatch.
module mc_main_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter bit EN_BNE = 1'b1,
    parameter bit EN_JAL = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] opcode_i,
    input  logic       zero_i,
    output logic       pc_write_o,
    output logic [1:0] pc_src_o,
    output logic       i_or_d_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_write_o,
    output logic [1:0] reg_dst_o,
    output logic [1:0] mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic       instr_done_o,
    output logic       illegal_op_o
);

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    ctrl_t      ctrl_dec, ctrl;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        op_d    = op_q;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                op_d = opcode_i;
                case (opcode_i)
                    OP_RTYPE:       state_d = S_R_EXEC;
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_BEQ:         state_d = S_BRANCH;
                    OP_BNE:         state_d = EN_BNE ? S_BRANCH : S_ILLEGAL;
                    OP_ADDI, OP_ANDI: state_d = S_IMM_EXEC;
                    OP_J:           state_d = S_JUMP;
                    OP_JAL:         state_d = EN_JAL ? S_JAL : S_ILLEGAL;
                    default:        state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = S_MEM_WB;
            S_R_EXEC:   state_d = S_R_WB;
            S_IMM_EXEC: state_d = S_IMM_WB;
            default:    state_d = S_FETCH;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .state_i (state_q),
        .op_i    (op_q),
        .zero_i  (zero_i),
        .ctrl_o  (ctrl_dec)
    );

    // Reset forces every strobe low so an abandoned instruction can never write.
    assign ctrl = rst_i ? '0 : ctrl_dec;

    assign pc_write_o   = ctrl.pc_write;
    assign pc_src_o     = ctrl.pc_src;
    assign i_or_d_o     = ctrl.i_or_d;
    assign mem_read_o   = ctrl.mem_read;
    assign mem_write_o  = ctrl.mem_write;
    assign ir_write_o   = ctrl.ir_write;
    assign reg_write_o  = ctrl.reg_write;
    assign reg_dst_o    = ctrl.reg_dst;
    assign mem_to_reg_o = ctrl.mem_to_reg;
    assign alu_src_a_o  = ctrl.alu_src_a;
    assign alu_src_b_o  = ctrl.alu_src_b;
    assign alu_op_o     = ctrl.alu_op;
    assign instr_done_o = ctrl.instr_done;
    assign illegal_op_o = ctrl.illegal_op;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed bench for mc_main_ctrl: per-instruction expected control sequence plus literal spot checks.
module tb_mc_main_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic       alu_src_a, instr_done, illegal_op;
    logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op;

    mc_main_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .opcode_i     (opcode),
        .zero_i       (zero),
        .pc_write_o   (pc_write),
        .pc_src_o     (pc_src),
        .i_or_d_o     (i_or_d),
        .mem_read_o   (mem_read),
        .mem_write_o  (mem_write),
        .ir_write_o   (ir_write),
        .reg_write_o  (reg_write),
        .reg_dst_o    (reg_dst),
        .mem_to_reg_o (mem_to_reg),
        .alu_src_a_o  (alu_src_a),
        .alu_src_b_o  (alu_src_b),
        .alu_op_o     (alu_op),
        .instr_done_o (instr_done),
        .illegal_op_o (illegal_op)
    );

    always #5 clk = ~clk;

    // Word layout: pcw[18] pcs[17:16] iord[15] mr[14] mw[13] irw[12] rw[11]
    //              rd[10:9] m2r[8:7] asa[6] asb[5:4] aop[3:2] done[1] ill[0]
    logic [18:0] dut_w;
    assign dut_w = {pc_write, pc_src, i_or_d, mem_read, mem_write, ir_write, reg_write,
                    reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, instr_done, illegal_op};

    int          total = 0;
    int          bad   = 0;
    logic [18:0] exp_w;
    logic        chk_en = 1'b0;
    int          cur_k;
    logic [18:0] obs [0:7];
    logic [18:0] expq [$];
    logic        watch_rw = 1'b0;
    logic        seen_rw  = 1'b0;

    function automatic logic [18:0] mk(input bit pcw, input bit [1:0] pcs, input bit iord,
                                       input bit mr, input bit mw, input bit irw, input bit rw,
                                       input bit [1:0] rd, input bit [1:0] m2r, input bit asa,
                                       input bit [1:0] asb, input bit [1:0] aop,
                                       input bit done, input bit ill);
        return {pcw, pcs, iord, mr, mw, irw, rw, rd, m2r, asa, asb, aop, done, ill};
    endfunction

    // Expected cycle-by-cycle control words for one whole instruction.
    task automatic build(input logic [5:0] op, input logic z);
        bit taken;
        expq.delete();
        expq.push_back(mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0));
        expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0));
        case (op)
            6'b100011: begin
                expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0));
                expq.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
                expq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0));
            end
            6'b101011: begin
                expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0));
                expq.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0));
            end
            6'b000000: begin
                expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
                expq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0));
            end
            6'b000100, 6'b000101: begin
                taken = (op == 6'b000101) ? !z : z;
                expq.push_back(mk(taken, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 1, 0));
            end
            6'b001000, 6'b001100: begin
                expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, (op == 6'b001100) ? 2'd3 : 2'd1, 0, 0));
                expq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0));
            end
            6'b000010: expq.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
            6'b000011: expq.push_back(mk(1, 2, 0, 0, 0, 0, 1, 2, 2, 0, 0, 1, 1, 0));
            default:   expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        endcase
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if (dut_w !== exp_w) begin
                bad++;
                $display("FAIL cycle_word k=%0d op=%b t=%0t: got %b want %b", cur_k, opcode, $time, dut_w, exp_w);
            end
            if (cur_k >= 0 && cur_k < 8) obs[cur_k] = dut_w;
            if (watch_rw && reg_write) seen_rw = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 of the next FETCH.
    task automatic run_instr(input logic [5:0] op, input logic z, input logic [5:0] op_after);
        int n;
        build(op, z);
        n = expq.size();
        for (int k = 0; k < n; k++) begin
            opcode = (k <= 1) ? op : op_after;
            zero   = z;
            exp_w  = expq[k];
            cur_k  = k;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst    = 1'b1;
        opcode = 6'b0;
        zero   = 1'b0;
        exp_w  = '0;
        cur_k  = -1;
        chk_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_outputs_zero", {13'd0, dut_w}, 32'd0);
        rst = 1'b0;
        exp_w = expq.size() == 0 ? mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0) : '0;
        #1;
        chk("fetch_mem_read", {31'd0, mem_read}, 32'd1);
        chk("fetch_ir_write", {31'd0, ir_write}, 32'd1);
        chk("fetch_pc_write", {31'd0, pc_write}, 32'd1);
        chk("fetch_alu_op",   {30'd0, alu_op},   32'd1);

        run_instr(6'b100011, 1'b0, 6'b100011);
        chk("lw_wb_reg_write",  {31'd0, obs[4][11]},  32'd1);
        chk("lw_wb_mem_to_reg", {30'd0, obs[4][8:7]}, 32'd1);
        chk("lw_wb_reg_dst",    {30'd0, obs[4][10:9]}, 32'd0);
        chk("lw_done_cycle5",   {30'd0, obs[4][1], obs[3][1]}, 32'd2);

        run_instr(6'b000000, 1'b0, 6'b101011);
        chk("r_exec_alu_op", {30'd0, obs[2][3:2]},  32'd0);
        chk("r_wb_reg_dst",  {30'd0, obs[3][10:9]}, 32'd1);

        run_instr(6'b101011, 1'b0, 6'b000000);

        run_instr(6'b000100, 1'b1, 6'b000100);
        chk("beq_z1_pc_write", {31'd0, obs[2][18]}, 32'd1);
        chk("beq_z1_pc_src",   {30'd0, obs[2][17:16]}, 32'd1);
        chk("beq_alu_op",      {30'd0, obs[2][3:2]}, 32'd2);
        run_instr(6'b000100, 1'b0, 6'b000100);
        chk("beq_z0_pc_write", {31'd0, obs[2][18]}, 32'd0);
        run_instr(6'b000101, 1'b0, 6'b000101);
        chk("bne_z0_pc_write", {31'd0, obs[2][18]}, 32'd1);
        run_instr(6'b000101, 1'b1, 6'b000101);
        chk("bne_z1_pc_write", {31'd0, obs[2][18]}, 32'd0);

        run_instr(6'b001100, 1'b0, 6'b001100);
        chk("andi_alu_op", {30'd0, obs[2][3:2]}, 32'd3);
        run_instr(6'b001000, 1'b0, 6'b001000);
        chk("addi_alu_op", {30'd0, obs[2][3:2]}, 32'd1);

        run_instr(6'b111111, 1'b0, 6'b111111);
        chk("illegal_pulse", {31'd0, obs[2][0]}, 32'd1);
        chk("illegal_no_writes", {28'd0, obs[2][18], obs[2][13], obs[2][12], obs[2][11]}, 32'd0);

        run_instr(6'b000010, 1'b0, 6'b000010);
        run_instr(6'b000011, 1'b0, 6'b000011);
        chk("jal_reg_dst",    {30'd0, obs[2][10:9]},  32'd2);
        chk("jal_mem_to_reg", {30'd0, obs[2][8:7]},   32'd2);
        chk("jal_pc_src",     {30'd0, obs[2][17:16]}, 32'd2);

        // lw abandoned by reset while in MEM_RD
        build(6'b100011, 1'b0);
        for (int k = 0; k < 3; k++) begin
            opcode = 6'b100011;
            exp_w  = expq[k];
            cur_k  = k;
            @(posedge clk);
            #1;
        end
        watch_rw = 1'b1;
        seen_rw  = 1'b0;
        rst      = 1'b1;
        exp_w    = '0;
        cur_k    = 3;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        exp_w = mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        cur_k = 0;
        @(negedge clk);
        #1;
        watch_rw = 1'b0;
        chk("rst_mid_no_reg_write", {31'd0, seen_rw}, 32'd0);
        chk("rst_mid_back_to_fetch", {31'd0, ir_write}, 32'd1);
        @(posedge clk);
        #1;
        // DUT is now in DECODE of whatever opcode was presented; finish it as an R-type.
        build(6'b000000, 1'b0);
        for (int k = 1; k < 4; k++) begin
            opcode = 6'b000000;
            exp_w  = expq[k];
            cur_k  = k;
            @(posedge clk);
            #1;
        end
        run_instr(6'b100011, 1'b0, 6'b000000);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
